// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction fetch path and the
// load/store path. One transaction is in flight at a time: the winner's fields
// are latched, presented on the memory port until accepted, and the response
// is routed back to whichever requester owns the transaction.
//
// Arbitration: data wins by default. A starvation counter tracks consecutive
// data wins while fetch is waiting; once it reaches STARVE_MAX, a pending
// fetch is forced through. A fetch flush (taken branch/jump) seen while fetch
// owns the port lets the memory transaction finish but swallows its response.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   fetch_req_i/addr_i      fetch request and address
//   fetch_flush_i           discard the outstanding fetch response
//   fetch_gnt_o             1-cycle pulse: fetch transaction latched
//   fetch_rvalid_o/rdata_o  1-cycle response pulse and held read data
//   data_req_i/we_i/addr_i/wdata_i/be_i   load/store request and fields
//   data_gnt_o              1-cycle pulse: data transaction latched
//   data_rvalid_o/rdata_o   1-cycle response pulse and held read data
//   mem_req_o..mem_be_o     memory request and latched transaction fields
//   mem_gnt_i               memory accepted the request
//   mem_rvalid_i/rdata_i    memory response (read data or write ack)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  fetch_req_i,
    input  logic [ADDR_W-1:0]     fetch_addr_i,
    input  logic                  fetch_flush_i,
    output logic                  fetch_gnt_o,
    output logic                  fetch_rvalid_o,
    output logic [DATA_W-1:0]     fetch_rdata_o,

    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [ADDR_W-1:0]     data_addr_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    input  logic [DATA_W/8-1:0]   data_be_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_W-1:0]     data_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e           state_q;
    logic             owner_data_q;   // 1: data path owns the port, 0: fetch
    logic             drop_q;         // fetch response to be swallowed
    logic [CNT_W-1:0] starve_cnt_q;

    logic fetch_wins;
    logic flush_hit;

    always_comb begin
        fetch_wins = fetch_req_i && (!data_req_i || (starve_cnt_q == CNT_MAX));
        // Only meaningful in REQ/WAIT, where owner_data_q is valid.
        flush_hit  = fetch_flush_i && !owner_data_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= StIdle;
            owner_data_q   <= 1'b0;
            drop_q         <= 1'b0;
            starve_cnt_q   <= '0;
            fetch_gnt_o    <= 1'b0;
            fetch_rvalid_o <= 1'b0;
            fetch_rdata_o  <= '0;
            data_gnt_o     <= 1'b0;
            data_rvalid_o  <= 1'b0;
            data_rdata_o   <= '0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            mem_be_o       <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            fetch_gnt_o    <= 1'b0;
            data_gnt_o     <= 1'b0;
            fetch_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    drop_q <= 1'b0;

                    if (!fetch_req_i || fetch_wins) begin
                        starve_cnt_q <= '0;
                    end else if (starve_cnt_q != CNT_MAX) begin
                        starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                    end

                    if (fetch_req_i || data_req_i) begin
                        state_q   <= StReq;
                        mem_req_o <= 1'b1;
                        if (fetch_wins) begin
                            owner_data_q <= 1'b0;
                            fetch_gnt_o  <= 1'b1;
                            mem_we_o     <= 1'b0;
                            mem_addr_o   <= fetch_addr_i;
                            mem_wdata_o  <= '0;
                            mem_be_o     <= '1;
                        end else begin
                            owner_data_q <= 1'b1;
                            data_gnt_o   <= 1'b1;
                            mem_we_o     <= data_we_i;
                            mem_addr_o   <= data_addr_i;
                            mem_wdata_o  <= data_wdata_i;
                            mem_be_o     <= data_we_i ? data_be_i : '1;
                        end
                    end
                end

                StReq: begin
                    if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= StWait;
                    end
                end

                StWait: begin
                    if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        state_q <= StIdle;
                        drop_q  <= 1'b0;
                        if (owner_data_q) begin
                            data_rdata_o  <= mem_rdata_i;
                            data_rvalid_o <= 1'b1;
                        end else if (!drop_q && !fetch_flush_i) begin
                            // A flush in the response cycle also suppresses it.
                            fetch_rdata_o  <= mem_rdata_i;
                            fetch_rvalid_o <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter: a table of single transactions, hand
// sequences for contention/starvation and reset, then randomized traffic
// checked cycle by cycle against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_flush_i;
    logic        fetch_gnt_o;
    logic        fetch_rvalid_o;
    logic [31:0] fetch_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i    = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i  = 32'h0;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_flush_i  (fetch_flush_i),
        .fetch_gnt_o    (fetch_gnt_o),
        .fetch_rvalid_o (fetch_rvalid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, data_gnt_o, data_rvalid_o,
                 data_rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o};
    endfunction

    // ------------------------------------------------------------------
    // Memory responder: acts on the falling edge, grants after a delay and
    // answers after a further delay (fixed or random).
    // ------------------------------------------------------------------
    int          cfg_gnt_dly = 0;
    int          cfg_rv_dly  = 0;
    bit          cfg_random  = 1'b0;
    logic [31:0] cfg_rdata   = 32'h0;
    bit          rsp_pend    = 1'b0;
    bit          rsp_seen    = 1'b0;
    int          rsp_gcnt    = 0;
    int          rsp_rcnt    = 0;

    always @(negedge clk_i) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (rsp_pend) begin
            if (rsp_rcnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = cfg_random ? $urandom : cfg_rdata;
                rsp_pend     = 1'b0;
            end else begin
                rsp_rcnt--;
            end
        end else if (mem_req_o) begin
            if (!rsp_seen) begin
                rsp_seen = 1'b1;
                rsp_gcnt = cfg_random ? int'($urandom_range(0, 3)) : cfg_gnt_dly;
            end
            if (rsp_gcnt == 0) begin
                mem_gnt_i = 1'b1;
                rsp_seen  = 1'b0;
                rsp_pend  = 1'b1;
                rsp_rcnt  = cfg_random ? int'($urandom_range(0, 2)) : cfg_rv_dly;
            end else begin
                rsp_gcnt--;
            end
        end else begin
            rsp_seen = 1'b0;
        end
    end

    // Expected held read data of each requester.
    logic [31:0] mdl_frd = 32'h0;
    logic [31:0] mdl_drd = 32'h0;

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        bit          flush;
        bit          exp_we;
        logic [3:0]  exp_be;
        bit          exp_deliver;
    } vec_t;

    function automatic vec_t mk(input bit fetch, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                                input bit flush, input bit exp_we, input logic [3:0] exp_be,
                                input bit exp_deliver);
        vec_t v;
        v.fetch = fetch; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.rdata = rdata; v.gnt_dly = gnt_dly; v.rv_dly = rv_dly; v.flush = flush;
        v.exp_we = exp_we; v.exp_be = exp_be; v.exp_deliver = exp_deliver;
        return v;
    endfunction

    task automatic scramble(input vec_t v);
        fetch_req_i  = 1'b0;
        data_req_i   = 1'b0;
        fetch_addr_i = ~v.addr;
        data_addr_i  = ~v.addr;
        data_we_i    = !v.we;
        data_wdata_i = ~v.wdata;
        data_be_i    = ~v.be;
    endtask

    // One isolated transaction; called #1 after an edge with the DUT idle.
    task automatic run_single(input vec_t v, input string tag);
        cfg_random   = 1'b0;
        cfg_gnt_dly  = v.gnt_dly;
        cfg_rv_dly   = v.rv_dly;
        cfg_rdata    = v.rdata;
        fetch_req_i  = v.fetch;
        fetch_addr_i = v.addr;
        data_req_i   = !v.fetch;
        data_we_i    = v.we;
        data_addr_i  = v.addr;
        data_wdata_i = v.wdata;
        data_be_i    = v.be;
        @(posedge clk_i); #1;
        check({tag, "_fetch_gnt"}, fetch_gnt_o, v.fetch);
        check({tag, "_data_gnt"}, data_gnt_o, !v.fetch);
        for (int k = 0; k <= v.gnt_dly; k++) begin
            if (k > 0) begin
                @(posedge clk_i); #1;
                check({tag, "_gnt_once"}, fetch_gnt_o | data_gnt_o, 1'b0);
            end
            if (k == 1) scramble(v);
            check({tag, "_mem_req"}, mem_req_o, 1'b1);
            check({tag, "_mem_addr"}, mem_addr_o, v.addr);
            check({tag, "_mem_we"}, mem_we_o, v.exp_we);
            check({tag, "_mem_be"}, mem_be_o, v.exp_be);
            if (v.exp_we) check({tag, "_mem_wdata"}, mem_wdata_o, v.wdata);
        end
        for (int k = 0; k <= v.rv_dly; k++) begin
            @(posedge clk_i); #1;
            scramble(v);
            fetch_flush_i = (k == 0) && v.flush;
            check({tag, "_wait_mem_req"}, mem_req_o, 1'b0);
            check({tag, "_wait_rvalid"}, fetch_rvalid_o | data_rvalid_o, 1'b0);
        end
        @(posedge clk_i); #1;
        fetch_flush_i = 1'b0;
        if (v.exp_deliver) begin
            if (v.fetch) mdl_frd = v.rdata;
            else         mdl_drd = v.rdata;
        end
        check({tag, "_fetch_rvalid"}, fetch_rvalid_o, v.fetch && v.exp_deliver);
        check({tag, "_data_rvalid"}, data_rvalid_o, !v.fetch && v.exp_deliver);
        check({tag, "_fetch_rdata"}, fetch_rdata_o, mdl_frd);
        check({tag, "_data_rdata"}, data_rdata_o, mdl_drd);
        @(posedge clk_i); #1;
        check({tag, "_rvalid_pulse"}, fetch_rvalid_o | data_rvalid_o, 1'b0);
    endtask

    // Reference-model transaction record for the random phase.
    bit          t_active   = 1'b0;
    bit          t_accepted = 1'b0;
    bit          t_fetch    = 1'b0;
    bit          t_drop     = 1'b0;
    bit          t_we       = 1'b0;
    logic [31:0] t_addr     = 32'h0;
    logic [31:0] t_wdata    = 32'h0;
    logic [3:0]  t_be       = 4'h0;
    int          starve     = 0;

    vec_t vecs[8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s_freq, s_dreq, s_dwe, s_flush, s_mgnt, s_mrv;
        logic [31:0] s_faddr, s_daddr, s_dwdata, s_mrdata;
        logic [3:0]  s_dbe;
        bit          e_fg, e_dg, e_frv, e_drv, e_mreq;
        bit          f_after, d_after;
        int          got;

        vecs[0] = mk(0, 0, 32'h100, 32'h0,        4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 4'hF, 1);
        vecs[1] = mk(0, 1, 32'h200, 32'h12345678, 4'h3, 32'h00000000, 0, 0, 0, 1, 4'h3, 1);
        vecs[2] = mk(1, 0, 32'h040, 32'h0,        4'h0, 32'h00000013, 0, 0, 0, 0, 4'hF, 1);
        vecs[3] = mk(1, 0, 32'h014, 32'h0,        4'h0, 32'h0640056F, 0, 1, 1, 0, 4'hF, 0);
        vecs[4] = mk(1, 0, 32'h078, 32'h0,        4'h0, 32'h00A00093, 0, 0, 0, 0, 4'hF, 1);
        vecs[5] = mk(0, 0, 32'h300, 32'hFFFF0000, 4'h1, 32'hCAFEF00D, 5, 0, 0, 0, 4'hF, 1);
        vecs[6] = mk(1, 0, 32'h080, 32'h0,        4'h0, 32'h11111111, 0, 0, 1, 0, 4'hF, 0);
        vecs[7] = mk(0, 1, 32'h304, 32'hA5A5A5A5, 4'hC, 32'h0000ABCD, 2, 1, 1, 1, 4'hC, 1);

        reset_i = 1'b1;
        fetch_req_i = 1'b0; fetch_addr_i = 32'h0; fetch_flush_i = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = 32'h0;
        data_wdata_i = 32'h0; data_be_i = 4'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outputs", any_out(), 1'b0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle_outputs", any_out(), 1'b0);

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) run_single(vecs[i], $sformatf("vec%0d", i));

        // Contention: data wins STARVE_MAX times, then fetch, repeating.
        cfg_random = 1'b0; cfg_gnt_dly = 0; cfg_rv_dly = 0; cfg_rdata = 32'h5A5A0001;
        fetch_req_i = 1'b1; fetch_addr_i = 32'h1000;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h2000;
        got = 0;
        for (int cyc = 0; cyc < 200 && got < 15; cyc++) begin
            @(posedge clk_i); #1;
            if (fetch_gnt_o || data_gnt_o) begin
                check($sformatf("contention_fetch_%0d", got), fetch_gnt_o, (got % 5) == 4);
                check($sformatf("contention_data_%0d", got), data_gnt_o, (got % 5) != 4);
                got++;
            end
        end
        if (got < 15) check("contention_timeout", got, 15);
        fetch_req_i = 1'b0; data_req_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        mdl_frd = 32'h5A5A0001;
        mdl_drd = 32'h5A5A0001;
        check("contention_fetch_rdata", fetch_rdata_o, mdl_frd);
        check("contention_data_rdata", data_rdata_o, mdl_drd);

        // Reset while the memory request is still waiting for a grant.
        cfg_gnt_dly = 4; cfg_rv_dly = 0;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h3F0;
        @(posedge clk_i); #1;
        check("rst_req_gnt", data_gnt_o, 1'b1);
        @(posedge clk_i); #1;
        data_req_i = 1'b0;
        check("rst_req_pending", mem_req_o, 1'b1);
        reset_i = 1'b1;
        #1;
        check("rst_req_async_drop", mem_req_o, 1'b0);
        check("rst_req_outputs", any_out(), 1'b0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        mdl_frd = 32'h0; mdl_drd = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;

        // Reset in WAIT; the memory answers after release and must be ignored.
        cfg_gnt_dly = 0; cfg_rv_dly = 3; cfg_rdata = 32'h77777777;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h400;
        @(posedge clk_i); #1;
        check("rst_wait_gnt", data_gnt_o, 1'b1);
        @(posedge clk_i); #1;
        data_req_i = 1'b0;
        check("rst_wait_mem_req", mem_req_o, 1'b0);
        reset_i = 1'b1;
        #1;
        check("rst_wait_outputs", any_out(), 1'b0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            check($sformatf("rst_no_rvalid_%0d", k), fetch_rvalid_o | data_rvalid_o, 1'b0);
            check($sformatf("rst_rdata_%0d", k), data_rdata_o, mdl_drd);
        end
        run_single(mk(0, 0, 32'h500, 32'h0, 4'hF, 32'h0BADC0DE, 0, 0, 0, 0, 4'hF, 1), "post_rst");

        // Randomized traffic against the reference model.
        cfg_random = 1'b1;
        f_after = 1'b0; d_after = 1'b0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            @(posedge clk_i);
            s_freq = fetch_req_i; s_faddr = fetch_addr_i; s_flush = fetch_flush_i;
            s_dreq = data_req_i; s_dwe = data_we_i; s_daddr = data_addr_i;
            s_dwdata = data_wdata_i; s_dbe = data_be_i;
            s_mgnt = mem_gnt_i; s_mrv = mem_rvalid_i; s_mrdata = mem_rdata_i;

            e_fg = 1'b0; e_dg = 1'b0; e_frv = 1'b0; e_drv = 1'b0;
            if (!t_active) begin
                if (s_freq || s_dreq) begin
                    t_fetch = s_freq && (!s_dreq || starve == int'(STARVE_MAX));
                    if (t_fetch || !s_freq) starve = 0;
                    else if (starve < int'(STARVE_MAX)) starve = starve + 1;
                    t_active   = 1'b1;
                    t_accepted = 1'b0;
                    t_drop     = 1'b0;
                    t_we       = !t_fetch && s_dwe;
                    t_addr     = t_fetch ? s_faddr : s_daddr;
                    t_wdata    = s_dwdata;
                    t_be       = t_we ? s_dbe : 4'hF;
                    e_fg       = t_fetch;
                    e_dg       = !t_fetch;
                end else begin
                    starve = 0;
                end
            end else begin
                if (t_fetch && s_flush) t_drop = 1'b1;
                if (!t_accepted) begin
                    t_accepted = s_mgnt;
                end else if (s_mrv) begin
                    t_active = 1'b0;
                    if (!t_fetch) begin
                        e_drv = 1'b1; mdl_drd = s_mrdata;
                    end else if (!t_drop) begin
                        e_frv = 1'b1; mdl_frd = s_mrdata;
                    end
                end
            end
            e_mreq = t_active && !t_accepted;

            #1;
            check($sformatf("rnd_fetch_gnt@%0d", cyc), fetch_gnt_o, e_fg);
            check($sformatf("rnd_data_gnt@%0d", cyc), data_gnt_o, e_dg);
            check($sformatf("rnd_fetch_rvalid@%0d", cyc), fetch_rvalid_o, e_frv);
            check($sformatf("rnd_data_rvalid@%0d", cyc), data_rvalid_o, e_drv);
            check($sformatf("rnd_fetch_rdata@%0d", cyc), fetch_rdata_o, mdl_frd);
            check($sformatf("rnd_data_rdata@%0d", cyc), data_rdata_o, mdl_drd);
            check($sformatf("rnd_mem_req@%0d", cyc), mem_req_o, e_mreq);
            if (e_mreq) begin
                check($sformatf("rnd_mem_fields@%0d", cyc),
                      {mem_addr_o, mem_we_o, mem_be_o, t_we ? mem_wdata_o : 32'h0},
                      {t_addr, t_we, t_be, t_we ? t_wdata : 32'h0});
            end

            if (cyc < 1500) begin
                if (!fetch_gnt_o && (!fetch_req_i || f_after)) begin
                    fetch_req_i  = ($urandom % 3) != 0;
                    fetch_addr_i = $urandom & 32'hFFFF_FFFC;
                end
                if (!data_gnt_o && (!data_req_i || d_after)) begin
                    data_req_i   = ($urandom % 3) != 0;
                    data_we_i    = $urandom_range(0, 1) == 1;
                    data_addr_i  = $urandom & 32'hFFFF_FFFC;
                    data_wdata_i = $urandom;
                    data_be_i    = 4'($urandom_range(0, 15));
                end
                fetch_flush_i = ($urandom % 5) == 0;
            end else begin
                fetch_req_i   = 1'b0;
                data_req_i    = 1'b0;
                fetch_flush_i = 1'b0;
            end
            f_after = fetch_gnt_o;
            d_after = data_gnt_o;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared single-port memory arbiter between the instruction fetch path and the load/store path of the decode/control stage. It accepts one transaction at a time from either requester, drives the single memory port, and routes the response back to the owner. Data accesses have fixed priority, and a starvation guard protects fetch. It also honours a fetch flush raised by a taken branch or jump.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive data wins over a pending fetch before fetch is forced

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- fetch_req_i  in  1  fetch request; held until fetch_gnt_o is seen
- fetch_addr_i  in  ADDR_W  fetch address
- fetch_flush_i  in  1  discard the outstanding fetch response (taken branch/JAL)
- fetch_gnt_o  out  1  one-cycle pulse: fetch transaction latched
- fetch_rvalid_o  out  1  one-cycle pulse: fetch_rdata_o valid
- fetch_rdata_o  out  DATA_W  fetch read data
- data_req_i  in  1  load/store request; held until data_gnt_o is seen
- data_we_i  in  1  1 = store, 0 = load
- data_addr_i  in  ADDR_W  load/store address
- data_wdata_i  in  DATA_W  store data
- data_be_i  in  DATA_W/8  store byte enables
- data_gnt_o  out  1  one-cycle pulse: data transaction latched
- data_rvalid_o  out  1  one-cycle pulse: load data valid or store acknowledged
- data_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request; held until mem_gnt_i
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/ADDR_W/DATA_W/DATA_W/8  latched transaction fields (mem_be_o forced all-ones on reads)
- mem_gnt_i  in  1  memory accepted the request this cycle
- mem_rvalid_i  in  1  response valid (read data or write ack); never in the same cycle as mem_gnt_i
- mem_rdata_i  in  DATA_W  memory read data

## Operation
- State machine: IDLE, REQ, WAIT.
- **IDLE:** at an edge with any request high, the arbiter picks the winner, latches its fields and owner ID, and moves to REQ.
  - Data wins by default.
  - Fetch wins if starve_cnt == STARVE_MAX and fetch_req_i is high.
  - IDLE ignores mem_rvalid_i.
- **REQ:**
  - The winner's gnt_o is high in the first REQ cycle only.
  - mem_req_o stays high with stable fields until mem_gnt_i is sampled, then the state moves to WAIT.
- **WAIT:** on mem_rvalid_i, mem_rdata_i is registered into the owner's rdata_o, the owner's rvalid_o is pulsed next cycle, and the state returns to IDLE.
- **starve_cnt** (width clog2(STARVE_MAX+1)), updated at every IDLE arbitration:
  - Increments when data wins while fetch_req_i is high.
  - Clears when fetch wins, or when fetch_req_i is low at arbitration.
  - Saturates at STARVE_MAX.
- **Flush:**
  - If fetch_flush_i is sampled high while the owner is fetch and the state is REQ or WAIT, a drop flag is set.
  - The memory transaction still completes.
  - fetch_rvalid_o is suppressed and fetch_rdata_o is not updated; the drop flag clears on return to IDLE.
  - Flush in IDLE, or while data owns the port, has no effect.
  - Flush sampled in the same cycle as mem_rvalid_i also suppresses the response.
- rdata_o holds its last value between responses.

## Timing
- Reset: all outputs 0, state IDLE, starve_cnt 0, drop flag 0.
- Reset mid-transaction: mem_req_o drops asynchronously, and no response is delivered for the aborted transaction.
- Minimum transaction (mem_gnt_i in the first REQ cycle, mem_rvalid_i one cycle later):
  - Edge 0: request sampled.
  - Cycle 1: gnt_o pulse, mem_req_o high.
  - Cycle 2: WAIT, mem_rvalid_i.
  - Cycle 3: rvalid_o pulse, back in IDLE and able to arbitrate.
  - Result: 3 cycles per transaction back-to-back.
- A requester must drop or change its request only after the edge ending its gnt_o cycle. A request still high at the next IDLE edge is treated as new.
- mem_req_o is never high outside REQ. fetch_rvalid_o and data_rvalid_o are never high together, and at most one rvalid_o pulse follows each gnt_o.

## Test plan
- **Single load:** data_req_i=1, addr 0x100, mem grants immediately and returns 0xDEADBEEF one cycle later → data_gnt_o at cycle 1, mem_addr_o=0x100, mem_we_o=0, data_rvalid_o with 0xDEADBEEF at cycle 3.
- **Store path:** data_we_i=1, wdata 0x12345678, be 0b0011 → mem_we_o=1, mem_be_o=0b0011, data_rvalid_o pulses after the write ack, fetch outputs stay 0.
- **Contention and starvation, STARVE_MAX=4:** fetch and data both request continuously → data is granted 4 times, fetch on the 5th, then the data-first pattern repeats.
- **Flush:** fetch addr 0x14 granted, fetch_flush_i pulsed in WAIT, memory returns 0x0640056F → no fetch_rvalid_o and fetch_rdata_o unchanged. The next fetch at 0x78 returns normally.
- **Memory backpressure:** mem_gnt_i held low for 5 cycles → mem_req_o and its fields stay stable 5 cycles, and the gnt_o pulse occurs only once.
- **Reset mid-WAIT:** reset_i asserted in WAIT, then mem_rvalid_i arrives after release → all outputs 0 during reset, no rvalid_o pulse, and the next request is served normally.
